// File: rtl/e203_exu_muldiv_wbck_fifo_if.sv
// Result channel between the muldiv engine, its write-back FIFO and the long-pipe arbiter.
// Handshake rule on both sides: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds valid and its data stable until then, and ready never depends on valid combinationally.
interface e203_exu_muldiv_wbck_fifo_if #(
  parameter int XLEN   = 32,
  parameter int ITAG_W = 1
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_wdat;
  logic              in_err;
  logic [ITAG_W-1:0] in_itag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_wdat;
  logic              out_err;
  logic [ITAG_W-1:0] out_itag;

  // FIFO side
  modport slave (
    input  in_valid, in_wdat, in_err, in_itag, out_ready,
    output in_ready, out_valid, out_wdat, out_err, out_itag
  );

  // Producer/consumer side (muldiv engine plus write-back arbiter)
  modport master (
    output in_valid, in_wdat, in_err, in_itag, out_ready,
    input  in_ready, out_valid, out_wdat, out_err, out_itag
  );
endinterface

// File: rtl/e203_exu_muldiv_wbck_fifo.sv
// Circular result buffer between the muldiv unit and the long-pipe write-back arbiter.
// Wrap-bit pointers give full/empty; a separate registered count is exported for observability.
module e203_exu_muldiv_wbck_fifo #(
  parameter int XLEN   = 32,
  parameter int ITAG_W = 1,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_pulse,
  e203_exu_muldiv_wbck_fifo_if.slave        io,
  output logic [CNT_W-1:0]                  buf_cnt,
  output logic                              buf_full,
  output logic                              buf_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = XLEN + 1 + ITAG_W;

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  assign buf_empty = (wptr == rptr);
  assign buf_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // Ready comes only from registered state and flush; out_ready never reaches in_ready,
  // which is why a full buffer cannot refill in the same cycle it drains.
  assign io.in_ready  = !buf_full && !flush_pulse;
  assign io.out_valid = !buf_empty && !flush_pulse;

  assign push = io.in_valid && io.in_ready;
  assign pop  = io.out_valid && io.out_ready;

  assign head = mem[rptr[AW-1:0]];
  assign {io.out_wdat, io.out_err, io.out_itag} = io.out_valid ? head : '0;

  // Storage is deliberately not reset; stale entries are hidden by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= {io.in_wdat, io.in_err, io.in_itag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_pulse) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt <= '0;
    end else if (flush_pulse) begin
      buf_cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + CNT_W'(1);
        2'b01:   buf_cnt <= buf_cnt - CNT_W'(1);
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_e203_exu_muldiv_wbck_fifo.sv
// Self-checking bench for the muldiv write-back FIFO: directed scenarios plus a random run
// compared against a queue-based reference model.
module tb_e203_exu_muldiv_wbck_fifo;
  localparam int XLEN   = 32;
  localparam int ITAG_W = 1;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int EW     = XLEN + 1 + ITAG_W;
  localparam int OW     = 2 + EW + CNT_W + 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush_pulse = 1'b0;
  logic [CNT_W-1:0] buf_cnt;
  logic             buf_full;
  logic             buf_empty;

  always #5 clk = ~clk;

  e203_exu_muldiv_wbck_fifo_if #(.XLEN(XLEN), .ITAG_W(ITAG_W)) io ();

  e203_exu_muldiv_wbck_fifo #(.XLEN(XLEN), .ITAG_W(ITAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_pulse (flush_pulse),
    .io          (io.slave),
    .buf_cnt     (buf_cnt),
    .buf_full    (buf_full),
    .buf_empty   (buf_empty)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] reset_vec;

  // Expected outputs: {in_ready, out_valid, wdat, err, itag, cnt, full, empty}
  function automatic logic [OW-1:0] model_outs();
    logic          ir;
    logic          ov;
    logic [EW-1:0] h;
    ir = (exp_q.size() < DEPTH) && !flush_pulse;
    ov = (exp_q.size() != 0) && !flush_pulse;
    h  = ov ? exp_q[0] : '0;
    return {ir, ov, h, CNT_W'(exp_q.size()), exp_q.size() == DEPTH, exp_q.size() == 0};
  endfunction

  function automatic logic [OW-1:0] dut_outs();
    return {io.in_ready, io.out_valid, io.out_wdat, io.out_err, io.out_itag, buf_cnt, buf_full, buf_empty};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [XLEN-1:0] d, input logic e,
                       input logic [ITAG_W-1:0] t, input logic ordy, input logic fl);
    io.in_valid  = v;
    io.in_wdat   = d;
    io.in_err    = e;
    io.in_itag   = t;
    io.out_ready = ordy;
    flush_pulse  = fl;
    #2;
  endtask

  task automatic tick();
    logic do_push;
    logic do_pop;
    logic fl;
    logic [EW-1:0] ent;
    fl      = flush_pulse;
    do_push = io.in_valid && (exp_q.size() < DEPTH) && !fl;
    do_pop  = io.out_ready && (exp_q.size() != 0) && !fl;
    ent     = {io.in_wdat, io.in_err, io.in_itag};
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(ent);
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (dut_outs() !== reset_vec) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", dut_outs(), reset_vec);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", io.in_ready); end
    n_checks++;
    if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", io.out_valid); end
    n_checks++;
    if (buf_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", buf_cnt); end
    n_checks++;
    if (io.out_wdat !== 32'h0) begin n_fail++; $display("FAIL reset_wdat: got %h expected 00000000", io.out_wdat); end
    tick();
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b expected 0", io.out_valid); end
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if ({io.out_valid, io.out_wdat, io.out_itag, buf_cnt} !== {1'b1, 32'h6, 1'b1, CNT_W'(1)}) begin
      n_fail++;
      $display("FAIL single_head: got v=%b d=%h t=%h c=%0d expected v=1 d=6 t=1 c=1",
               io.out_valid, io.out_wdat, io.out_itag, buf_cnt);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if ({io.out_valid, buf_cnt} !== {1'b0, CNT_W'(0)}) begin
      n_fail++;
      $display("FAIL single_drained: got v=%b c=%0d expected v=0 c=0", io.out_valid, buf_cnt);
    end
    tick();
  endtask

  task automatic test_fill();
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({buf_full, io.in_ready, buf_cnt} !== {1'b1, 1'b0, CNT_W'(2)}) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b rdy=%b c=%0d expected full=1 rdy=0 c=2", buf_full, io.in_ready, buf_cnt);
    end
    tick();
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({io.in_ready, io.out_wdat} !== {1'b0, 32'hA}) begin
      n_fail++;
      $display("FAIL fill_pop_a: got rdy=%b d=%h expected rdy=0 d=a", io.in_ready, io.out_wdat);
    end
    tick();
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({io.in_ready, buf_cnt, io.out_wdat} !== {1'b1, CNT_W'(1), 32'hB}) begin
      n_fail++;
      $display("FAIL fill_refill: got rdy=%b c=%0d d=%h expected rdy=1 c=1 d=b", io.in_ready, buf_cnt, io.out_wdat);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (io.out_wdat !== 32'hB) begin n_fail++; $display("FAIL fill_pop_b: got %h expected b", io.out_wdat); end
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if ({io.out_wdat, buf_cnt} !== {32'hC, CNT_W'(1)}) begin
      n_fail++;
      $display("FAIL fill_pop_c: got d=%h c=%0d expected d=c c=1", io.out_wdat, buf_cnt);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b expected 1", buf_empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, XLEN'(i), 1'b0, ITAG_W'(i), 1'b1, 1'b0);
      if (i > 0) begin
        n_checks++;
        if ({io.out_valid, io.out_wdat, buf_cnt, io.in_ready} !== {1'b1, XLEN'(i - 1), CNT_W'(1), 1'b1}) begin
          n_fail++;
          $display("FAIL stream_%0d: got v=%b d=%h c=%0d rdy=%b expected v=1 d=%h c=1 rdy=1",
                   i, io.out_valid, io.out_wdat, buf_cnt, io.in_ready, i - 1);
        end
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if ({io.out_valid, io.out_wdat} !== {1'b1, 32'h9}) begin
      n_fail++;
      $display("FAIL stream_last: got v=%b d=%h expected v=1 d=9", io.out_valid, io.out_wdat);
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if ({io.out_err, buf_cnt} !== {1'b1, CNT_W'(2)}) begin
      n_fail++;
      $display("FAIL flush_pre: got err=%b c=%0d expected err=1 c=2", io.out_err, buf_cnt);
    end
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({io.in_ready, io.out_valid, io.out_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_cycle: got rdy=%b v=%b err=%b expected 0 0 0", io.in_ready, io.out_valid, io.out_err);
    end
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if ({buf_cnt, buf_empty, io.out_err} !== {CNT_W'(0), 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_after: got c=%0d empty=%b err=%b expected 0 1 0", buf_cnt, buf_empty, io.out_err);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_outs() !== reset_vec) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h expected %h", dut_outs(), reset_vec);
    end
    exp_q.delete();
    io.in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if ({io.out_valid, buf_cnt, buf_empty} !== {1'b0, CNT_W'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset_lost: got v=%b c=%0d empty=%b expected 0 0 1", io.out_valid, buf_cnt, buf_empty);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), ITAG_W'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      n_checks++;
      if (dut_outs() !== model_outs()) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h", i, dut_outs(), model_outs());
      end
      tick();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_vec = {1'b1, 1'b0, EW'(0), CNT_W'(0), 1'b0, 1'b1};
    io.in_valid = 1'b0; io.in_wdat = '0; io.in_err = 1'b0; io.in_itag = '0; io.out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/e203_exu_muldiv_wbck_fifo.md
# e203_exu_muldiv_wbck_fifo

Result buffer sitting directly downstream of the E203 multiply/divide unit, between its `muldiv_o_*` result handshake and the long-pipe write-back arbiter. It captures completed MUL/DIV results (data, error flag, instruction tag) in a small circular FIFO. This decouples the multi-cycle muldiv engine from write-back back-pressure, so a finished result never stalls the engine while the arbiter serves other sources. Flush support discards buffered results on pipeline flush.

## Interface
Parameters
- XLEN, 32, result data width
- ITAG_W, 1, instruction tag width (matches OITF tag width)
- DEPTH, 2, entry count; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports
- clk  input  1  core clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush_pulse  input  1  single-cycle pipeline flush
- in_valid  input  1  result valid from muldiv (`muldiv_o_valid`)
- in_ready  output  1  FIFO can accept (`muldiv_o_ready`)
- in_wdat  input  XLEN  result data
- in_err  input  1  result error flag
- in_itag  input  ITAG_W  tag of producing instruction
- out_valid  output  1  head entry valid toward write-back arbiter
- out_ready  input  1  arbiter accepts head entry
- out_wdat  output  XLEN  head data; 0 when empty
- out_err  output  1  head error; 0 when empty
- out_itag  output  ITAG_W  head tag; 0 when empty
- buf_cnt  output  CNT_W  number of valid entries
- buf_full  output  1  buf_cnt == DEPTH
- buf_empty  output  1  buf_cnt == 0

## Operation
- Storage: DEPTH entries of {wdat, err, itag}. Pointers wptr/rptr are log2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
- Empty: wptr == rptr. Full: low bits equal and wrap bits differ.
- in_ready = !buf_full & !flush_pulse.
- Push = in_valid & in_ready. Writes entry[wptr] and advances wptr.
- out_valid = !buf_empty & !flush_pulse.
- Pop = out_valid & out_ready. Advances rptr.
- Output fields show entry[rptr] when out_valid, else all zero.
- No bypass: a pushed result becomes visible at the output the cycle after the push.
- Simultaneous push and pop when not full: both pointers advance and buf_cnt is unchanged. When full, in_ready is 0, so there is no same-cycle refill even if a pop occurs.
- Flush: while flush_pulse is high, no push or pop occurs. On the next edge, wptr, rptr and buf_cnt go to 0. Entry contents are left as-is but are unobservable.
- buf_cnt is a register updated per edge as +1 (push only), −1 (pop only) or unchanged. It never exceeds DEPTH and never underflows. buf_full and buf_empty are decoded from the pointers and must agree with buf_cnt.
- Storage RAM has no reset. Pointers and count reset asynchronously.

## Timing
- Reset (rst_n low, any time, including mid-transfer): in_ready=1, out_valid=0, out_wdat=0, out_err=0, out_itag=0, buf_cnt=0, buf_empty=1, buf_full=0. These take effect immediately, without waiting for a clock edge.
- Latency from in handshake to out_valid: 1 cycle.
- Throughput: 1 result/cycle sustained when out_ready is held 1.
- in_ready depends only on registered state and flush_pulse. There is no combinational path from out_ready.
- out_valid and the output fields depend only on registered state and flush_pulse.
- Pointer wrap: after DEPTH pushes, the low bits return to 0 and the wrap bit toggles. Ordering is strictly FIFO across the wrap.

## Test plan
- Reset then idle: with rst_n released, check in_ready=1, out_valid=0, buf_cnt=0, out_wdat=0x00000000.
- Single result: push wdat=0x0000_0006, err=0, itag=1 with out_ready=0. Next cycle out_valid=1, out_wdat=6, out_itag=1, buf_cnt=1. Then raise out_ready: buf_cnt returns to 0 and out_valid=0 next cycle.
- Fill and back-pressure: with out_ready=0, push 0xA, then 0xB. buf_full=1 and in_ready=0. A third in_valid (0xC) is not accepted. Pop one: in_ready=1 the following cycle and 0xC is accepted. Pop order must be 0xA, 0xB, 0xC.
- Streaming and wrap: with in_valid=1 and out_ready=1 every cycle for 10 results 0..9, output order is 0..9, buf_cnt stays 1 after the first cycle, and both pointers wrap at least twice.
- Flush: with 2 entries buffered (err=1 on the head), assert flush_pulse with in_valid=1. That cycle in_ready=0 and out_valid=0. Next cycle buf_cnt=0, buf_empty=1, out_err=0.
- Async reset mid-operation: with 1 entry buffered and a push in progress, pulse rst_n low between edges. Outputs drop to reset values immediately, and the push is lost.
